// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: unpacks the EX/MEM bus, resolves branch/jump redirect,
// runs the req/ready handshake to a variable-latency data memory (stalling the
// pipeline while it waits) and registers the MEM/WB bus toward writeback.
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [106:0] exmem_in,
   input  logic [31:0]  mem_rdata,
   input  logic         mem_ready,
   output logic         mem_req,
   output logic         mem_we,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wdata,
   output logic         stall,
   output logic         pc_src,
   output logic [31:0]  pc_branch,
   output logic         jump,
   output logic         mem_err,
   output logic [70:0]  memwb_out
);

   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic {StIdle, StWait} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
   logic              mem_err_q, mem_err_d;
   logic [70:0]       memwb_q, memwb_d;

   // EX/MEM field unpacking
   logic        zero, reg_write, mem_to_reg, mem_write, branch_eq;
   logic [4:0]  write_reg;
   logic [31:0] alu_out, write_data, pc_branch_f;

   assign zero        = exmem_in[0];
   assign reg_write   = exmem_in[1];
   assign mem_to_reg  = exmem_in[2];
   assign mem_write   = exmem_in[3];
   assign branch_eq   = exmem_in[4];
   assign jump        = exmem_in[5];
   assign write_reg   = exmem_in[10:6];
   assign alu_out     = exmem_in[42:11];
   assign write_data  = exmem_in[74:43];
   assign pc_branch_f = exmem_in[106:75];

   logic access, timeout_hit, load_done;
   logic [31:0] rdata;

   assign access      = mem_to_reg | mem_write;
   // Last WAIT cycle: the access is force-completed instead of stalling again
   assign timeout_hit = (state_q == StWait) && (wait_cnt_q == CntLast) && !mem_ready;

   assign mem_req   = (state_q == StWait) ? 1'b1 : access;
   assign mem_we    = mem_write;
   assign mem_addr  = alu_out;
   assign mem_wdata = write_data;
   assign pc_src    = zero & branch_eq;
   assign pc_branch = pc_branch_f;
   assign stall     = mem_req & ~mem_ready & ~timeout_hit;
   assign mem_err   = mem_err_q;
   assign memwb_out = memwb_q;

   // Only a load that actually got mem_ready returns memory data
   assign load_done = mem_req & mem_ready & mem_to_reg & ~mem_write;
   assign rdata     = load_done ? mem_rdata : 32'h0;

   // Handshake FSM, timeout counter, sticky error and MEM/WB next-state
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      memwb_d    = stall ? 71'b0 : {rdata, alu_out, write_reg, mem_to_reg, reg_write};
      unique case (state_q)
         StIdle: begin
            if (access && !mem_ready) begin
               state_d    = StWait;
               wait_cnt_d = CntW'(1);
            end
         end
         StWait: begin
            if (mem_ready) begin
               state_d    = StIdle;
               wait_cnt_d = '0;
            end else if (timeout_hit) begin
               state_d    = StIdle;
               wait_cnt_d = '0;
               mem_err_d  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
         memwb_q    <= 71'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
         memwb_q    <= memwb_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus a randomized
// instruction stream checked against a latency-based reference model.
module tb_mem_stage_ctrl;

   localparam int unsigned TIMEOUT = 16;

   logic         clk = 1'b0;
   logic         clr;
   logic [106:0] exmem_in;
   logic [31:0]  mem_rdata;
   logic         mem_ready;
   logic         mem_req, mem_we, stall, pc_src, jump, mem_err;
   logic [31:0]  mem_addr, mem_wdata, pc_branch;
   logic [70:0]  memwb_out;

   int checks = 0;
   int errors = 0;

   mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .clr       (clr),
      .exmem_in  (exmem_in),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .stall     (stall),
      .pc_src    (pc_src),
      .pc_branch (pc_branch),
      .jump      (jump),
      .mem_err   (mem_err),
      .memwb_out (memwb_out)
   );

   always #5 clk = ~clk;

   function automatic logic [106:0] pack(input logic z, input logic rw, input logic mtr,
                                         input logic mw, input logic beq, input logic j,
                                         input logic [4:0] wr, input logic [31:0] alu,
                                         input logic [31:0] wd, input logic [31:0] pcb);
      return {pcb, wd, alu, wr, j, beq, mw, mtr, rw, z};
   endfunction

   // Advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr       = 1'b0;
      exmem_in  = {$urandom, $urandom, $urandom, $urandom};
      mem_rdata = $urandom;
      mem_ready = 1'b0;
      step();
      step();
      checks++;
      if (memwb_out !== 71'b0) begin
         errors++;
         $display("FAIL reset_memwb got %h want 0", memwb_out);
      end
      checks++;
      if (mem_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got %b want 0", mem_err);
      end
      clr      = 1'b1;
      exmem_in = '0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle req %b stall %b want 0 0", mem_req, stall);
      end
      step();
   endtask

   task automatic test_alu();
      exmem_in  = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, $urandom, $urandom);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL alu_req_stall req %b stall %b want 0 0", mem_req, stall);
      end
      step();
      checks++;
      if (memwb_out !== {32'h0, 32'h1234, 5'd5, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL alu_memwb got %h want %h", memwb_out,
                  {32'h0, 32'h1234, 5'd5, 1'b0, 1'b1});
      end
   endtask

   task automatic test_load_wait();
      exmem_in = pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h40, $urandom, $urandom);
      for (int c = 0; c < 4; c++) begin
         mem_ready = (c == 3);
         mem_rdata = (c == 3) ? 32'hDEADBEEF : $urandom;
         #1;
         checks++;
         if (stall !== (c < 3) || mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            errors++;
            $display("FAIL load_cycle%0d stall %b req %b addr %h want %b 1 00000040",
                     c, stall, mem_req, mem_addr, c < 3);
         end
         step();
         checks++;
         if (memwb_out !== ((c < 3) ? 71'b0 : {32'hDEADBEEF, 32'h40, 5'd7, 1'b1, 1'b1})) begin
            errors++;
            $display("FAIL load_memwb%0d got %h", c, memwb_out);
         end
      end
   endtask

   task automatic test_store();
      exmem_in  = pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h80, 32'hA5A5A5A5, $urandom);
      mem_ready = 1'b1;
      mem_rdata = 32'hFFFF0001;
      #1;
      checks++;
      if (mem_we !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b1 || mem_wdata !== 32'hA5A5A5A5)
      begin
         errors++;
         $display("FAIL store_comb we %b stall %b req %b wdata %h want 1 0 1 a5a5a5a5",
                  mem_we, stall, mem_req, mem_wdata);
      end
      step();
      checks++;
      if (memwb_out !== {32'h0, 32'h80, 5'd3, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL store_memwb got %h want %h", memwb_out,
                  {32'h0, 32'h80, 5'd3, 1'b0, 1'b0});
      end
   endtask

   task automatic test_timeout();
      exmem_in  = pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h200, $urandom, $urandom);
      mem_ready = 1'b0;
      for (int c = 0; c < int'(TIMEOUT); c++) begin
         mem_rdata = $urandom;
         #1;
         checks++;
         if (stall !== (c < int'(TIMEOUT) - 1)) begin
            errors++;
            $display("FAIL timeout_stall%0d got %b want %b", c, stall, c < int'(TIMEOUT) - 1);
         end
         step();
         if (c == int'(TIMEOUT) - 2) begin
            checks++;
            if (mem_err !== 1'b0) begin
               errors++;
               $display("FAIL timeout_early_err got %b want 0", mem_err);
            end
         end
      end
      checks++;
      if (memwb_out !== {32'h0, 32'h200, 5'd9, 1'b1, 1'b1} || mem_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_forced memwb %h err %b want %h 1", memwb_out, mem_err,
                  {32'h0, 32'h200, 5'd9, 1'b1, 1'b1});
      end
      exmem_in = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 32'h55, $urandom, $urandom);
      #1;
      checks++;
      if (stall !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL timeout_next_alu stall %b req %b want 0 0", stall, mem_req);
      end
      step();
      checks++;
      if (memwb_out !== {32'h0, 32'h55, 5'd4, 1'b0, 1'b1} || mem_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_after memwb %h err %b want %h 1", memwb_out, mem_err,
                  {32'h0, 32'h55, 5'd4, 1'b0, 1'b1});
      end
   endtask

   task automatic test_branch();
      exmem_in = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h100);
      #1;
      checks++;
      if (pc_src !== 1'b1 || pc_branch !== 32'h100 || jump !== 1'b0) begin
         errors++;
         $display("FAIL branch_taken src %b pcb %h jump %b want 1 00000100 0",
                  pc_src, pc_branch, jump);
      end
      exmem_in = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0, 32'h0, 32'h100);
      #1;
      checks++;
      if (pc_src !== 1'b0 || jump !== 1'b1) begin
         errors++;
         $display("FAIL branch_not_taken src %b jump %b want 0 1", pc_src, jump);
      end
      step();
   endtask

   task automatic test_clr_mid_wait();
      // Load with a taken branch: redirect must show even while stalled
      exmem_in  = pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 32'h300, 32'h0, 32'h440);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b1 || pc_src !== 1'b1) begin
         errors++;
         $display("FAIL clr_branch_stall stall %b src %b want 1 1", stall, pc_src);
      end
      step();
      step();
      step();
      clr = 1'b0;
      #1;
      checks++;
      if (memwb_out !== 71'b0 || mem_err !== 1'b0) begin
         errors++;
         $display("FAIL clr_mid_wait memwb %h err %b want 0 0", memwb_out, mem_err);
      end
      exmem_in = '0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL clr_dropped req %b stall %b want 0 0", mem_req, stall);
      end
      step();
      clr       = 1'b1;
      exmem_in  = pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h44, 32'h0, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'h0BADF00D;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL clr_then_load stall %b want 0", stall);
      end
      step();
      checks++;
      if (memwb_out !== {32'h0BADF00D, 32'h44, 5'd6, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL clr_then_load_memwb got %h", memwb_out);
      end
   endtask

   // Randomized back-to-back stream. Each instruction is described by its kind and
   // the number of cycles memory keeps mem_ready low; expectations follow from that.
   task automatic test_random();
      logic        err_model = 1'b0;
      logic [70:0] exp_wb;
      for (int n = 0; n < 200; n++) begin
         int unsigned kind = $urandom_range(0, 2);
         int unsigned lat;
         logic        z   = 1'($urandom);
         logic        beq = 1'($urandom);
         logic        j   = 1'($urandom);
         logic        rw  = (kind == 2) ? 1'b0 : 1'($urandom);
         logic [4:0]  wr  = 5'($urandom);
         logic [31:0] alu = $urandom;
         logic        acc = (kind != 0);
         lat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
         exmem_in = pack(z, rw, kind == 1, kind == 2, beq, j, wr, alu, $urandom, $urandom);
         for (int k = 0; k < int'(TIMEOUT); k++) begin
            logic exp_stall, ready_now;
            ready_now = acc ? (k == int'(lat)) : 1'($urandom);
            mem_ready = ready_now;
            mem_rdata = $urandom;
            #1;
            exp_stall = acc && (k < int'(lat)) && (k < int'(TIMEOUT) - 1);
            checks++;
            if (stall !== exp_stall || mem_req !== acc || pc_src !== (z & beq) || jump !== j)
            begin
               errors++;
               $display("FAIL rand%0d_cyc%0d stall %b req %b src %b jump %b want %b %b %b %b",
                        n, k, stall, mem_req, pc_src, jump, exp_stall, acc, z & beq, j);
            end
            if (exp_stall) exp_wb = 71'b0;
            else exp_wb = {(kind == 1 && ready_now) ? mem_rdata : 32'h0, alu, wr,
                           kind == 1, rw};
            if (acc && !exp_stall && !ready_now) err_model = 1'b1;
            step();
            checks++;
            if (memwb_out !== exp_wb || mem_err !== err_model) begin
               errors++;
               $display("FAIL rand%0d_wb%0d memwb %h err %b want %h %b",
                        n, k, memwb_out, mem_err, exp_wb, err_model);
            end
            if (!exp_stall) break;
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_wait();
      test_store();
      test_timeout();
      test_branch();
      test_clr_mid_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
